aes_block_assembler: RTL and testbench

Byte-stream front end for the AES datapath. Accepts plaintext or ciphertext one byte at a time over a valid/ready handshake, packs bytes into 128-bit blocks (first byte in bits [127:120]), and pads the final partial block. Completed blocks are buffered in a small FIFO and presented over a valid/ready block handshake to the SPI master's `message` input, which drives the Cipher/Decipher slaves.

---
 rtl/aes_stream_pkg.sv | 22 ++
 rtl/aes_block_fifo.sv | 54 +++++
 rtl/aes_block_assembler.sv | 146 ++++++++++++++
 tb/tb_aes_block_assembler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared types for the AES byte-stream front end.
// Block geometry, assembler states, FIFO entry layout.
package aes_stream_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic {
        FILL,
        PAD
    } asmState_t;

    typedef struct packed {
        logic [127:0] data;
        logic [4:0]   len;
        logic         last;
    } blkEntry_t;

    function automatic logic [7:0] pad_byte(input logic [4:0] n);
        return 8'(5'd16 - n);
    endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Small block FIFO between the assembler and the SPI message port.
// Head entry is read straight from the storage flops.
module aes_block_fifo
    import aes_stream_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  blkEntry_t                  pushEntry,
    input  logic                       pop,
    output blkEntry_t                  headEntry,
    output logic                       headValid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    blkEntry_t       mem [DEPTH];
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic            doPop;

    assign headValid = (count != '0);
    assign headEntry = mem[rdPtr];
    assign doPop     = pop && headValid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushEntry;
                wrPtr      <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_block_assembler.sv
// Packs a byte stream into padded 128-bit AES blocks behind a FIFO.
// Define AES_PKCS7_PAD_EN for PKCS#7 padding (else zero padding).
module aes_block_assembler
    import aes_stream_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [127:0] blk_data,
    output logic [4:0]   blk_len,
    output logic         blk_last
);

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef AES_PKCS7_PAD_EN
    localparam logic PKCS7 = 1'b1;
`else
    localparam logic PKCS7 = 1'b0;
`endif

    logic [CW-1:0] fifoCount;
    logic [3:0]    idx;
    logic [119:0]  lanes;
    logic          alive;
    logic          notFull;
    logic          fillState;
    logic          padPush;
    logic          accept;
    logic          complete;
    logic [7:0]    padVal;
    blkEntry_t     asmEntry;
    blkEntry_t     pushEntry;
    blkEntry_t     headEntry;

    assign notFull  = fifoCount < CW'(DEPTH);
    assign in_ready = alive && fillState && notFull;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || idx == 4'hf);

`ifdef AES_PKCS7_PAD_EN
    asmState_t state;
    asmState_t stateNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= stateNext;
        end
    end

    // Message ending on a block boundary still owes a full pad block.
    always_comb begin
        stateNext = state;
        padPush   = 1'b0;
        unique case (state)
            FILL: begin
                if (accept && in_last && idx == 4'hf) begin
                    stateNext = PAD;
                end
            end
            PAD: begin
                if (notFull) begin
                    padPush   = 1'b1;
                    stateNext = FILL;
                end
            end
            default: stateNext = FILL;
        endcase
    end

    assign fillState = (state == FILL);
`else
    assign fillState = 1'b1;
    assign padPush   = 1'b0;
`endif

    always_comb begin
        asmEntry = '0;
        padVal   = PKCS7 ? pad_byte({1'b0, idx} + 5'd1) : 8'h00;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (4'(k) < idx) begin
                asmEntry.data[127-8*k -: 8] = lanes[119-8*k -: 8];
            end else if (4'(k) == idx) begin
                asmEntry.data[127-8*k -: 8] = in_byte;
            end else begin
                asmEntry.data[127-8*k -: 8] = padVal;
            end
        end
        asmEntry.len  = {1'b0, idx} + 5'd1;
        asmEntry.last = in_last && !(PKCS7 && idx == 4'hf);
    end

    always_comb begin
        pushEntry = asmEntry;
        if (padPush) begin
            pushEntry.data = {BLOCK_BYTES{8'h10}};
            pushEntry.len  = 5'd0;
            pushEntry.last = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx   <= '0;
            lanes <= '0;
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (accept) begin
                idx <= complete ? 4'd0 : idx + 4'd1;
                for (int k = 0; k < BLOCK_BYTES - 1; k++) begin
                    if (!complete && 4'(k) == idx) begin
                        lanes[119-8*k -: 8] <= in_byte;
                    end
                end
            end
        end
    end

    aes_block_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (complete || padPush),
        .pushEntry (pushEntry),
        .pop       (blk_ready),
        .headEntry (headEntry),
        .headValid (blk_valid),
        .count     (fifoCount)
    );

    assign blk_data = headEntry.data;
    assign blk_len  = headEntry.len;
    assign blk_last = headEntry.last;

endmodule

// File: tb/tb_aes_block_assembler.sv
// Directed bench for aes_block_assembler (both padding builds).
module tb_aes_block_assembler;

`ifdef AES_PKCS7_PAD_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_byte = 8'h00;
    logic         in_last = 1'b0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [127:0] blk_data;
    logic [4:0]   blk_len;
    logic         blk_last;

    aes_block_assembler #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_len   (blk_len),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   len;
        logic         last;
    } blk_t;

    typedef struct {
        int           n;
        logic [7:0]   base;
        logic [7:0]   step;
        logic [127:0] data;
        logic [4:0]   len;
    } vec_t;

    blk_t q[$];
    int   passCnt = 0;
    int   totalCnt = 0;
    int   stalls = 0;
    int   sawValid = 0;

    always @(posedge clk) begin
        if (reset && blk_valid && blk_ready)
            q.push_back('{blk_data, blk_len, blk_last});
        if (blk_valid)
            sawValid++;
    end

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic chkBlk(input string nm, input int i,
                          input logic [127:0] d,
                          input logic [4:0] l,
                          input logic la);
        if (i < q.size()) begin
            chk({nm, " data"}, q[i].data, d);
            chk({nm, " len"}, 128'(q[i].len), 128'(l));
            chk({nm, " last"}, 128'(q[i].last), 128'(la));
        end else begin
            totalCnt++;
            $display("FAIL %s: block %0d missing, got %0d blocks",
                     nm, i, q.size());
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t > 0) stalls++;
        if (!in_ready) begin
            totalCnt++;
            $display("FAIL accept timeout: byte %0h never accepted", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [127:0] pack(input logic [7:0] base,
                                          input logic [7:0] step);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = 8'(base + step * 8'(i));
        return r;
    endfunction

    vec_t vecs[5];

    initial begin
        vecs[0] = '{16, 8'h00, 8'h11,
                    128'h00112233445566778899aabbccddeeff, 5'd16};
        vecs[1] = '{5, 8'h01, 8'h01,
                    PK ? {40'h0102030405, {11{8'h0b}}}
                       : {40'h0102030405, 88'h0}, 5'd5};
        vecs[2] = '{1, 8'ha5, 8'h00,
                    PK ? {8'ha5, {15{8'h0f}}}
                       : {8'ha5, 120'h0}, 5'd1};
        vecs[3] = '{15, 8'h10, 8'h01,
                    PK ? {120'h101112131415161718191a1b1c1d1e, 8'h01}
                       : {120'h101112131415161718191a1b1c1d1e, 8'h00},
                    5'd15};
        vecs[4] = '{16, 8'hf0, 8'h01,
                    128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 5'd16};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst in_ready", 128'(in_ready), 128'(0));
        chk("rst blk_valid", 128'(blk_valid), 128'(0));
        chk("rst blk_data", blk_data, 128'h0);
        chk("rst blk_len", 128'(blk_len), 128'(0));
        chk("rst blk_last", 128'(blk_last), 128'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst in_ready", 128'(in_ready), 128'(1));

        // table-driven single-message vectors
        blk_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            int nb;
            q.delete();
            for (int i = 0; i < vecs[v].n; i++)
                sendByte(8'(vecs[v].base + vecs[v].step * 8'(i)),
                         i == vecs[v].n - 1);
            chk($sformatf("v%0d latency", v), 128'(blk_valid), 128'(1));
            repeat (4) @(posedge clk);
            #1;
            nb = (PK && vecs[v].n == 16) ? 2 : 1;
            chk($sformatf("v%0d count", v), 128'(q.size()), 128'(nb));
            chkBlk($sformatf("v%0d", v), 0, vecs[v].data, vecs[v].len,
                   !(PK && vecs[v].n == 16));
            if (nb == 2)
                chkBlk($sformatf("v%0d pad", v), 1,
                       {16{8'h10}}, 5'd0, 1'b1);
        end

        // backpressure: FIFO fills after two blocks
        q.delete();
        blk_ready = 1'b0;
        for (int i = 0; i < 32; i++) sendByte(8'(i), 1'b0);
        chk("bp full in_ready", 128'(in_ready), 128'(0));
        chk("bp head", blk_data, pack(8'h00, 8'h01));
        repeat (3) @(negedge clk);
        chk("bp stable valid", 128'(blk_valid), 128'(1));
        chk("bp stable data", blk_data, pack(8'h00, 8'h01));
        chk("bp stable len", 128'(blk_len), 128'(16));
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp reopen in_ready", 128'(in_ready), 128'(1));
        for (int i = 32; i < 48; i++) sendByte(8'(i), i == 47);
        repeat (6) @(posedge clk);
        #1;
        chk("bp count", 128'(q.size()), 128'(PK ? 4 : 3));
        for (int k = 0; k < 3; k++)
            chkBlk($sformatf("bp blk%0d", k), k,
                   pack(8'(16 * k), 8'h01), 5'd16, (k == 2) && !PK);
        if (PK) chkBlk("bp pad", 3, {16{8'h10}}, 5'd0, 1'b1);

        // reset mid-block discards the partial block
        q.delete();
        for (int i = 0; i < 7; i++) sendByte(8'hc0 + 8'(i), 1'b0);
        @(negedge clk);
        reset = 1'b0;
        sawValid = 0;
        #1;
        chk("midrst in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst no block", 128'(sawValid), 128'(0));
        for (int i = 0; i < 16; i++)
            sendByte(8'h20 + 8'(i), i == 15);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst count", 128'(q.size()), 128'(PK ? 2 : 1));
        chkBlk("midrst blk", 0, pack(8'h20, 8'h01), 5'd16, !PK);

        // back-to-back push/pop, no stalls
        q.delete();
        stalls = 0;
        for (int i = 0; i < 64; i++)
            sendByte(8'(8'h80 + i), i == 63);
        chk("b2b stalls", 128'(stalls), 128'(0));
        repeat (4) @(posedge clk);
        #1;
        chk("b2b count", 128'(q.size()), 128'(PK ? 5 : 4));
        for (int k = 0; k < 4; k++)
            chkBlk($sformatf("b2b blk%0d", k), k,
                   pack(8'(8'h80 + 16 * k), 8'h01), 5'd16,
                   (k == 3) && !PK);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
